// File: rtl/shift_unit_arbiter_if.sv
// Requester, shifter and response signals shared by shift_unit_arbiter and its neighbours.
interface shift_unit_arbiter_if #(
  parameter int unsigned N = 8
);
  logic         req0_valid;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req0_ready;
  logic         req1_valid;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req1_ready;
  logic [N-1:0] sh_a;
  logic [N-1:0] sh_b;
  logic [N-1:0] sh_out;
  logic         rsp_valid;
  logic         rsp_id;
  logic [N-1:0] rsp_data;
  logic         rsp_ready;
  logic         busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, sh_out, rsp_ready,
    output req0_ready, req1_ready, sh_a, sh_b, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, sh_out, rsp_ready,
    input  req0_ready, req1_ready, sh_a, sh_b, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Arbitrates two requesters onto one external logical-right shifter and returns tagged results.
// Define SHARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to req0.
module shift_unit_arbiter #(
  parameter int unsigned N = 8
) (
  input logic                 clk,
  input logic                 rst,
  shift_unit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_sh_a;
  logic [N-1:0] r_sh_b;
  logic         r_cur_id;
  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic [N-1:0] r_rsp_data;
  logic         r_busy;
  logic         w_grant;
  logic         w_grant_id;
  logic         w_req0_ready;
  logic         w_req1_ready;
`ifdef SHARB_ROUND_ROBIN_EN
  logic         r_last_grant;
`endif

  // Winner selection; only meaningful when at least one valid is high
  always_comb begin
    w_grant_id = !bus.req0_valid;
`ifdef SHARB_ROUND_ROBIN_EN
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_id = !r_last_grant;
    end
`endif
  end

  // Next state and same-cycle ready
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((bus.req0_valid || bus.req1_valid) && !rst) begin
          w_grant      = 1'b1;
          w_req0_ready = !w_grant_id;
          w_req1_ready = w_grant_id;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_cur_id    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
`ifdef SHARB_ROUND_ROBIN_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_sh_a   <= w_grant_id ? bus.req1_a : bus.req0_a;
        r_sh_b   <= w_grant_id ? bus.req1_b : bus.req0_b;
        r_cur_id <= w_grant_id;
`ifdef SHARB_ROUND_ROBIN_EN
        r_last_grant <= w_grant_id;
`endif
      end
      if (r_state == S_ISSUE) begin
        r_rsp_data  <= bus.sh_out;
        r_rsp_id    <= r_cur_id;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == S_RESP) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = w_req0_ready;
  assign bus.req1_ready = w_req1_ready;
  assign bus.sh_a       = r_sh_a;
  assign bus.sh_b       = r_sh_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.busy       = r_busy;

endmodule
